// File: rtl/rv16_mem_pkg.sv
// Shared types and constants for the rv16 unified-memory arbiter.
package rv16_mem_pkg;

    // Default geometry: 1024 x 16-bit words
    localparam int unsigned DefAddrW = 10;
    localparam int unsigned DefDataW = 16;

    // Data-streak counter width; holds MAX_D_STREAK values up to 15
    localparam int unsigned StreakW = 4;

    // Which port owns the read data returning this cycle
    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_IF   = 2'd1,
        R_D    = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/rv16_arb_pick.sv
// Combinational grant picker: data wins unless fetch has waited out the streak limit.
module rv16_arb_pick
    import rv16_mem_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 3
) (
    input  logic               if_req_i,
    input  logic               d_req_i,
    input  logic [StreakW-1:0] streak_i,
    output logic               if_gnt_o,
    output logic               d_gnt_o
);

    localparam logic [StreakW-1:0] MaxStreak = StreakW'(MAX_D_STREAK);

    // Data has priority; a full streak with fetch waiting hands the slot to fetch
    always_comb begin
        d_gnt_o  = d_req_i & ~(if_req_i & (streak_i == MaxStreak));
        if_gnt_o = if_req_i & ~d_gnt_o;
    end

endmodule

// File: rtl/rv16_mem_arbiter.sv
// Arbiter sharing one registered single-port RAM between rv16r fetch and load/store.
// Optional build macro ARB_PERF_EN adds contention/stall counters and a
// request-withdrawal assertion.
module rv16_mem_arbiter
    import rv16_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefAddrW,
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned MAX_D_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [15:0]       perf_conflict,
    output logic [15:0]       perf_if_stall
`endif
);

    localparam logic [StreakW-1:0] MaxStreak = StreakW'(MAX_D_STREAK);

    logic [StreakW-1:0] streak_q, streak_d;
    rd_owner_e          owner_q, owner_d;
    logic               if_req_v, d_req_v;

    // Reset blocks new grants in the same cycle
    assign if_req_v = if_req & ~rst;
    assign d_req_v  = d_req & ~rst;

    rv16_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_pick (
        .if_req_i (if_req_v),
        .d_req_i  (d_req_v),
        .streak_i (streak_q),
        .if_gnt_o (if_gnt),
        .d_gnt_o  (d_gnt)
    );

    // Count data grants taken while fetch waits; any fetch grant or idle fetch clears it
    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_gnt) begin
            streak_d = '0;
        end else if (d_gnt && (streak_q < MaxStreak)) begin
            streak_d = streak_q + StreakW'(1);
        end
    end

    // Remember who owns next cycle's read data; stores return nothing
    always_comb begin
        owner_d = R_NONE;
        if (if_gnt) begin
            owner_d = R_IF;
        end else if (d_gnt && !d_we) begin
            owner_d = R_D;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= R_NONE;
            streak_q <= '0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    // RAM port mux and response steering; reset also masks a response in flight
    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = d_gnt ? d_addr : if_addr;
        mem_wdata = mem_we ? d_wdata : '0;
        if_rvalid = (owner_q == R_IF) & ~rst;
        d_rvalid  = (owner_q == R_D) & ~rst;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

`ifdef ARB_PERF_EN
    logic [15:0] conflict_q, stall_q;

    // Saturating contention and fetch-stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
            stall_q    <= '0;
        end else begin
            if (if_req && d_req && (conflict_q != 16'hFFFF)) begin
                conflict_q <= conflict_q + 16'd1;
            end
            if (if_req && !if_gnt && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign perf_conflict = conflict_q;
    assign perf_if_stall = stall_q;

`ifndef SYNTHESIS
    // A waiting request must stay up until it is granted
    a_if_hold: assert property (@(posedge clk) disable iff (rst)
        (if_req && !if_gnt) |=> if_req)
        else $error("if_req withdrawn before if_gnt");
    a_d_hold: assert property (@(posedge clk) disable iff (rst)
        (d_req && !d_gnt) |=> d_req)
        else $error("d_req withdrawn before d_gnt");
`endif
`endif

endmodule

// File: tb/tb_rv16_mem_arbiter.sv
// Self-checking bench for rv16_mem_arbiter: directed cases plus randomized traffic
// compared every cycle against a behavioural model of the arbiter and RAM.
module tb_rv16_mem_arbiter;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 16;
    localparam int unsigned MAX_D = 3;

    logic          clk, rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef ARB_PERF_EN
    logic [15:0]   perf_conflict, perf_if_stall;
`endif

    rv16_mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_D_STREAK (MAX_D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_PERF_EN
        ,
        .perf_conflict (perf_conflict),
        .perf_if_stall (perf_if_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-port RAM driven by the DUT
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    // Reference model state
    logic [DW-1:0] ref_mem [1024];
    int            m_streak;     // data grants in a row while fetch waited
    int            m_pend;       // 0 none, 1 fetch, 2 data response due next cycle
    logic [DW-1:0] m_pdata;
    int            m_conf, m_stall;

    int checks, failures;
    logic s_ig, s_dg, s_iv, s_dv, s_en, s_we;
    logic [DW-1:0] s_ird, s_drd, s_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One cycle: compare DUT at the negedge against the model, then advance the model
    task automatic tick();
        logic eg, edg, eiv, edv;
        logic [DW-1:0] eird, edrd;
        @(negedge clk);
        edg  = d_req && !rst && !(if_req && (m_streak == int'(MAX_D)));
        eg   = if_req && !rst && !edg;
        eiv  = !rst && (m_pend == 1);
        edv  = !rst && (m_pend == 2);
        eird = eiv ? m_pdata : '0;
        edrd = edv ? m_pdata : '0;
        chk("if_gnt", 32'(if_gnt), 32'(eg));
        chk("d_gnt", 32'(d_gnt), 32'(edg));
        chk("mem_en", 32'(mem_en), 32'(eg | edg));
        chk("mem_we", 32'(mem_we), 32'(edg & d_we));
        if (eg || edg) chk("mem_addr", 32'(mem_addr), 32'(edg ? d_addr : if_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'((edg && d_we) ? d_wdata : 16'h0));
        chk("if_rvalid", 32'(if_rvalid), 32'(eiv));
        chk("if_rdata", 32'(if_rdata), 32'(eird));
        chk("d_rvalid", 32'(d_rvalid), 32'(edv));
        chk("d_rdata", 32'(d_rdata), 32'(edrd));
`ifdef ARB_PERF_EN
        chk("perf_conflict", 32'(perf_conflict), 32'(m_conf));
        chk("perf_if_stall", 32'(perf_if_stall), 32'(m_stall));
`endif
        s_ig = if_gnt; s_dg = d_gnt; s_iv = if_rvalid; s_dv = d_rvalid;
        s_ird = if_rdata; s_drd = d_rdata; s_en = mem_en; s_we = mem_we; s_wd = mem_wdata;
        if (rst) begin
            m_streak = 0; m_pend = 0; m_conf = 0; m_stall = 0;
        end else begin
            if (if_req && d_req && m_conf < 65535) m_conf++;
            if (if_req && !eg && m_stall < 65535) m_stall++;
            if (!if_req || eg) m_streak = 0;
            else if (edg && m_streak < int'(MAX_D)) m_streak++;
            m_pend = 0;
            if (eg) begin
                m_pend = 1; m_pdata = ref_mem[if_addr];
            end else if (edg && !d_we) begin
                m_pend = 2; m_pdata = ref_mem[d_addr];
            end
            if (edg && d_we) ref_mem[d_addr] = d_wdata;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [7:0] seq;
        checks = 0; failures = 0;
        m_streak = 0; m_pend = 0; m_pdata = '0; m_conf = 0; m_stall = 0;
        ram_q = '0;
        for (int i = 0; i < 1024; i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            ram[i] = v; ref_mem[i] = v;
        end
        for (int i = 0; i < 4; i++) begin
            ram[i] = 16'hA000 + 16'(i); ref_mem[i] = 16'hA000 + 16'(i);
        end
        ram[5] = 16'h1234; ref_mem[5] = 16'h1234;

        // Reset with both requests pending: nothing may be granted
        rst = 1'b1; if_req = 1'b1; if_addr = 10'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020; d_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_if_gnt", 32'(s_ig), 32'd0);
            chk("rst_d_gnt", 32'(s_dg), 32'd0);
            chk("rst_mem_en", 32'(s_en), 32'd0);
            chk("rst_rvalid", 32'({s_iv, s_dv}), 32'd0);
            adv();
        end
        rst = 1'b0;

        // Contention for 8 cycles: D,D,D,I,D,D,D,I
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seq[i] = s_ig;
            chk("contend_one_gnt", 32'(s_ig ^ s_dg), 32'd1);
`ifdef ARB_PERF_EN
            if (i == 5) begin
                chk("perf_conflict_5", 32'(perf_conflict), 32'd5);
                chk("perf_if_stall_4", 32'(perf_if_stall), 32'd4);
            end
`endif
            adv();
        end
        chk("contend_seq", 32'(seq), 32'h88);
        if_req = 1'b0; d_req = 1'b0;
        tick(); adv();

        // Single fetch from 0x005
        if_req = 1'b1; if_addr = 10'h005;
        tick();
        chk("fetch_gnt", 32'(s_ig), 32'd1);
        adv();
        if_req = 1'b0;
        tick();
        chk("fetch_rvalid", 32'(s_iv), 32'd1);
        chk("fetch_rdata", 32'(s_ird), 32'h1234);
        chk("fetch_no_drvalid", 32'(s_dv), 32'd0);
        adv();

        // Store 0xBEEF to 0x3FF then load it back
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FF; d_wdata = 16'hBEEF;
        tick();
        chk("store_gnt", 32'(s_dg), 32'd1);
        chk("store_we", 32'(s_we), 32'd1);
        chk("store_wdata", 32'(s_wd), 32'hBEEF);
        adv();
        d_we = 1'b0;
        tick();
        chk("load_gnt", 32'(s_dg), 32'd1);
        chk("store_no_rvalid", 32'(s_dv), 32'd0);
        adv();
        d_req = 1'b0;
        tick();
        chk("load_rvalid", 32'(s_dv), 32'd1);
        chk("load_rdata", 32'(s_drd), 32'hBEEF);
        adv();

        // Back-to-back fetches from 0..3
        for (int i = 0; i < 4; i++) begin
            if_req = 1'b1; if_addr = AW'(i);
            tick();
            chk("b2b_gnt", 32'(s_ig), 32'd1);
            if (i > 0) begin
                chk("b2b_rvalid", 32'(s_iv), 32'd1);
                chk("b2b_rdata", 32'(s_ird), 32'hA000 + 32'(i - 1));
            end
            adv();
        end
        if_req = 1'b0;
        tick();
        chk("b2b_last_rdata", 32'(s_ird), 32'hA003);
        adv();

        // Reset in the cycle after a load grant drops its response
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
        tick();
        chk("rstmid_gnt", 32'(s_dg), 32'd1);
        adv();
        d_req = 1'b0; rst = 1'b1;
        tick();
        chk("rstmid_drvalid", 32'(s_dv), 32'd0);
        adv();
        rst = 1'b0; if_req = 1'b1; if_addr = 10'h001;
        tick();
        chk("rstmid_no_resp", 32'(s_dv), 32'd0);
        chk("rstmid_next_gnt", 32'(s_ig), 32'd1);
        adv();
        if_req = 1'b0;
        tick();
        chk("rstmid_next_rdata", 32'(s_ird), 32'hA001);
        adv();

        // Randomized traffic with requests held until granted and occasional reset
        for (int n = 0; n < 3000; n++) begin
            tick();
            adv();
            if (s_ig) if_req = 1'b0;
            if (s_dg) d_req = 1'b0;
            if (!if_req && $urandom_range(0, 3) != 0) begin
                if_req = 1'b1; if_addr = rand_addr();
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = rand_addr(); d_wdata = DW'($urandom);
            end
            rst = ($urandom_range(0, 149) == 0);
        end
        tick();
        adv();
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv16_mem_arbiter.md
Name: rv16_mem_arbiter

Overview:
- Shares one single-port 16-bit word RAM between the rv16r instruction-fetch port and the load/store port.
- Grants at most one access per cycle. Read data returns one cycle after the grant.
- Data port has priority, bounded by an anti-starvation limit.
- Sits between the rv16r core and the unified memory array, replacing the separate instruction/data RAMs.

Parameters:
- ADDR_W, 10, word-address width (1024 words).
- DATA_W, 16, data word width.
- MAX_D_STREAK, 3, max consecutive data grants while fetch is waiting; the next grant goes to fetch. Legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (cycle after if_gnt)
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  load/store request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  load data valid (cycle after a load d_gnt; never asserted for stores)
- d_rdata  out  DATA_W  load data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; registered RAM, valid one cycle after mem_en with mem_we=0

Behaviour:
- Arbitration (combinational from registered state):
  - Only if_req: grant fetch.
  - Only d_req: grant data.
  - Both: grant data unless streak == MAX_D_STREAK, then grant fetch.
- At most one of if_gnt/d_gnt is high in a cycle.
- mem_en = if_gnt | d_gnt. mem_we = d_gnt & d_we. mem_addr/mem_wdata are muxed from the winner. mem_wdata = 0 when no write.
- Streak counter (4 bits):
  - Increments on a data grant while if_req is high.
  - Clears on any fetch grant, or on any cycle with if_req low.
  - Saturates at MAX_D_STREAK.
- Read-owner FSM, registered, states R_NONE / R_IF / R_D:
  - Next state is R_IF on fetch grant, R_D on a load grant, otherwise R_NONE. A store grant leads to R_NONE.
- Responses:
  - if_rvalid = (state == R_IF); d_rvalid = (state == R_D).
  - rdata outputs carry mem_rdata when their rvalid is high, else 0.
- Throughput: back-to-back grants every cycle with no bubbles. A new grant may coincide with the previous rvalid.
- Store-then-load to the same address in consecutive cycles returns the new data, since the RAM write completes before the following read.
- Reset (synchronous, takes priority over everything):
  - State R_NONE, streak 0.
  - All gnt/rvalid/mem_en/mem_we low; rdata 0.
  - Reset mid-read drops the pending rvalid; no response is produced for it.
- Requesters must not drop req before gnt. Arbiter behaviour on a withdrawn request is undefined, and the assertion below flags it.

Optional Feature:
- Macro ARB_PERF_EN.
- When defined, adds outputs:
  - perf_conflict (16-bit): count of cycles with both requests high.
  - perf_if_stall (16-bit): count of cycles with if_req high and no if_gnt.
- Both counters saturate at 0xFFFF and clear on rst.
- Also adds a simulation-only assertion that fires if if_req or d_req drops before its grant.
- When not defined: no extra ports, no counters, no assertion.

Decomposition:
- Package rv16_mem_pkg:
  - read-owner enum (R_NONE, R_IF, R_D)
  - default ADDR_W/DATA_W constants
  - streak counter width constant
- One natural sub-module: rv16_arb_pick. Purely combinational; takes if_req, d_req and streak, and returns the grant pair. The FSM, counters and muxing stay in the top.

Test Plan:
- Reset, then fetch only: if_req=1, if_addr=0x005, mem holds 0x1234 → if_gnt the same cycle, if_rvalid=1 with if_rdata=0x1234 next cycle; d_rvalid stays 0.
- Store then load: d_req with d_we=1, addr=0x3FF, wdata=0xBEEF, then a load from 0x3FF → no d_rvalid for the store; d_rvalid=1 and d_rdata=0xBEEF one cycle after the load grant.
- Contention with MAX_D_STREAK=3: if_req and d_req held high for 8 cycles → grant sequence D,D,D,I,D,D,D,I; no cycle has both grants.
- Back-to-back fetches at addresses 0..3 → if_gnt high on 4 consecutive cycles, if_rvalid high on the next 4 with in-order data.
- rst asserted in the cycle after a load grant → d_rvalid stays 0, state returns to R_NONE, streak 0, and the next request is granted normally.
- With ARB_PERF_EN: 5 contention cycles → perf_conflict=5 and perf_if_stall=4 (one fetch grant among the 5 cycles, by streak rule with MAX_D_STREAK=3).
